// File: rtl/ucsbece154b_gshare_bp_if.sv
// Fetch-lookup and execute-update signal bundle for the gshare branch predictor.
// The predictor takes the slave modport; the datapath (or a bench) drives the master side.
interface ucsbece154b_gshare_bp_if #(
    parameter int GHR_BITS  = 6,
    parameter int RAS_DEPTH = 8
);
    localparam int RP_W = $clog2(RAS_DEPTH);

    logic [31:0]         pc_i;
    logic                fetch_adv_i;
    logic                taken_o;
    logic [31:0]         target_o;
    logic [GHR_BITS-1:0] ghr_o;
    logic [RP_W-1:0]     ras_ptr_o;

    logic                upd_valid_i;
    logic [31:0]         upd_pc_i;
    logic [1:0]          upd_type_i;
    logic                upd_taken_i;
    logic [31:0]         upd_target_i;
    logic [GHR_BITS-1:0] upd_ghr_i;
    logic [RP_W-1:0]     upd_ras_ptr_i;
    logic                upd_mispredict_i;

    modport master (
        output pc_i, fetch_adv_i,
        output upd_valid_i, upd_pc_i, upd_type_i, upd_taken_i, upd_target_i,
        output upd_ghr_i, upd_ras_ptr_i, upd_mispredict_i,
        input  taken_o, target_o, ghr_o, ras_ptr_o
    );

    modport slave (
        input  pc_i, fetch_adv_i,
        input  upd_valid_i, upd_pc_i, upd_type_i, upd_taken_i, upd_target_i,
        input  upd_ghr_i, upd_ras_ptr_i, upd_mispredict_i,
        output taken_o, target_o, ghr_o, ras_ptr_o
    );
endinterface

// File: rtl/ucsbece154b_gshare_bp.sv
// Gshare predictor: tagged direct-mapped BTB with entry types, PC^GHR indexed PHT,
// speculative GHR with checkpoint restore. Define RAS_EN to add a circular return stack.
module ucsbece154b_gshare_bp #(
    parameter int BTB_ENTRIES = 32,
    parameter int TAG_BITS    = 8,
    parameter int GHR_BITS    = 6,
    parameter int CTR_BITS    = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset_ni,
    ucsbece154b_gshare_bp_if.slave   bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int RP_W  = $clog2(RAS_DEPTH);
    localparam int PHT_N = 1 << GHR_BITS;

    localparam logic [1:0] T_BR   = 2'd0;
    localparam logic [1:0] T_JMP  = 2'd1;
    localparam logic [1:0] T_CALL = 2'd2;
    localparam logic [1:0] T_RET  = 2'd3;

    localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (&c) ? c : c + CTR_ONE;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
    logic [1:0]             btb_type   [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [CTR_BITS-1:0]    pht        [PHT_N];
    logic [GHR_BITS-1:0]    ghr;

    logic [IDX-1:0]      f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [GHR_BITS-1:0] f_pidx;
    logic                f_hit;
    logic [1:0]          f_type;
    logic                f_dir;
    logic [31:0]         pc_plus4;
    logic [31:0]         ras_top;
    logic                pred_taken;
    logic [31:0]         pred_target;

    logic [IDX-1:0]      u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic [GHR_BITS-1:0] u_pidx;
    logic                u_misp;
    logic                spec_adv;

    assign f_idx    = bus.pc_i[IDX+1:2];
    assign f_tag    = bus.pc_i[IDX+TAG_BITS+1:IDX+2];
    assign f_pidx   = bus.pc_i[GHR_BITS+1:2] ^ ghr;
    assign f_hit    = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_type   = btb_type[f_idx];
    assign f_dir    = pht[f_pidx][CTR_BITS-1];
    assign pc_plus4 = bus.pc_i + 32'd4;

    assign u_idx    = bus.upd_pc_i[IDX+1:2];
    assign u_tag    = bus.upd_pc_i[IDX+TAG_BITS+1:IDX+2];
    assign u_pidx   = bus.upd_pc_i[GHR_BITS+1:2] ^ bus.upd_ghr_i;
    assign u_misp   = bus.upd_valid_i && bus.upd_mispredict_i;
    assign spec_adv = bus.fetch_adv_i && f_hit;

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (f_hit) begin
            case (f_type)
                T_BR: begin
                    pred_taken = f_dir;
                    if (f_dir) pred_target = btb_target[f_idx];
                end
                T_JMP, T_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = btb_target[f_idx];
                end
                default: begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end
            endcase
        end
    end

    // Outputs are forced to the sequential fall-through while reset is held.
    assign bus.taken_o  = reset_ni && pred_taken;
    assign bus.target_o = reset_ni ? pred_target : pc_plus4;
    assign bus.ghr_o    = reset_ni ? ghr : '0;

    // A resolved mispredict restores the checkpoint and wins over the fetch-side shift.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ghr <= '0;
        end else if (u_misp) begin
            if (bus.upd_type_i == T_BR) ghr <= {bus.upd_ghr_i[GHR_BITS-2:0], bus.upd_taken_i};
            else                        ghr <= bus.upd_ghr_i;
        end else if (spec_adv && (f_type == T_BR)) begin
            ghr <= {ghr[GHR_BITS-2:0], f_dir};
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_WNT;
        end else if (bus.upd_valid_i && (bus.upd_type_i == T_BR)) begin
            pht[u_pidx] <= bus.upd_taken_i ? sat_inc(pht[u_pidx]) : sat_dec(pht[u_pidx]);
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni)                                   btb_valid        <= '0;
        else if (bus.upd_valid_i && bus.upd_taken_i)     btb_valid[u_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (bus.upd_valid_i && bus.upd_taken_i) begin
            btb_tag[u_idx]    <= u_tag;
            btb_type[u_idx]   <= bus.upd_type_i;
            btb_target[u_idx] <= bus.upd_target_i;
        end
    end

`ifdef RAS_EN
    localparam logic [RP_W-1:0] RP_ONE = {{(RP_W-1){1'b0}}, 1'b1};

    logic [31:0]     ras [RAS_DEPTH];
    logic [RP_W-1:0] ras_ptr;

    // Pointer addresses the next free slot; the top of stack sits one below it.
    assign ras_top       = ras[ras_ptr - RP_ONE];
    assign bus.ras_ptr_o = reset_ni ? ras_ptr : '0;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni)                          ras_ptr <= '0;
        else if (u_misp)                        ras_ptr <= bus.upd_ras_ptr_i;
        else if (spec_adv && f_type == T_CALL)  ras_ptr <= ras_ptr + RP_ONE;
        else if (spec_adv && f_type == T_RET)   ras_ptr <= ras_ptr - RP_ONE;
    end

    always_ff @(posedge clk) begin
        if (spec_adv && (f_type == T_CALL)) ras[ras_ptr] <= pc_plus4;
    end

    logic unused_upd;
    assign unused_upd = ^bus.upd_pc_i;
`else
    assign ras_top       = btb_target[f_idx];
    assign bus.ras_ptr_o = {RP_W{1'b0}};

    logic unused_upd;
    assign unused_upd = ^{bus.upd_pc_i, bus.upd_ras_ptr_i};
`endif

endmodule

// File: tb/tb_ucsbece154b_gshare_bp.sv
// Directed bench for ucsbece154b_gshare_bp; RAS checks compile in when RAS_EN is defined.
module tb_ucsbece154b_gshare_bp;
    localparam int GHR_BITS  = 6;
    localparam int RAS_DEPTH = 8;
    localparam int RP_W      = $clog2(RAS_DEPTH);
    localparam logic [1:0] BR = 2'd0, JMP = 2'd1, CALL = 2'd2, RET = 2'd3;

    logic clk;
    logic reset_ni;
    int   vectors;
    int   miscompares;

    ucsbece154b_gshare_bp_if #(.GHR_BITS(GHR_BITS), .RAS_DEPTH(RAS_DEPTH)) bus ();

    ucsbece154b_gshare_bp #(
        .BTB_ENTRIES(32), .TAG_BITS(8), .GHR_BITS(GHR_BITS), .CTR_BITS(2), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within its time limit");
        $fatal(1, "timeout");
    end

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [1:0] ty,
                           input logic tk, input logic [31:0] tg, input logic [GHR_BITS-1:0] g,
                           input logic [RP_W-1:0] rp, input logic mp);
        bus.upd_valid_i      = v;
        bus.upd_pc_i         = pc;
        bus.upd_type_i       = ty;
        bus.upd_taken_i      = tk;
        bus.upd_target_i     = tg;
        bus.upd_ghr_i        = g;
        bus.upd_ras_ptr_i    = rp;
        bus.upd_mispredict_i = mp;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, BR, 1'b0, 32'h0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        bus.pc_i = 32'h100;
        bus.fetch_adv_i = 1'b0;
        idle();
        @(negedge clk); #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL reset_taken got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h104) begin miscompares++; $display("FAIL reset_target got=%h exp=00000104", bus.target_o); end
        vectors++; if (bus.ghr_o !== 6'd0) begin miscompares++; $display("FAIL reset_ghr got=%b exp=000000", bus.ghr_o); end
        vectors++; if (bus.ras_ptr_o !== 3'd0) begin miscompares++; $display("FAIL reset_ras_ptr got=%0d exp=0", bus.ras_ptr_o); end
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_train();
        // counter 01 -> 10 -> 11 at PHT index 0
        repeat (2) begin
            set_upd(1'b1, 32'h100, BR, 1'b1, 32'h80, 6'd0, '0, 1'b0);
            @(negedge clk);
        end
        idle();
        bus.pc_i = 32'h100; #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL train_taken got=%b exp=1", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h80) begin miscompares++; $display("FAIL train_target got=%h exp=00000080", bus.target_o); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        repeat (5) begin
            set_upd(1'b1, 32'h100, BR, 1'b1, 32'h80, 6'd0, '0, 1'b0);
            @(negedge clk);
        end
        set_upd(1'b1, 32'h100, BR, 1'b0, 32'h0, 6'd0, '0, 1'b0);
        @(negedge clk); idle(); #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL sat_10_taken got=%b exp=1", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h80) begin miscompares++; $display("FAIL sat_10_target got=%h exp=00000080", bus.target_o); end
        set_upd(1'b1, 32'h100, BR, 1'b0, 32'h0, 6'd0, '0, 1'b0);
        @(negedge clk); idle(); #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL sat_01_taken got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h104) begin miscompares++; $display("FAIL sat_01_target got=%h exp=00000104", bus.target_o); end
        set_upd(1'b1, 32'h100, BR, 1'b0, 32'h0, 6'd0, '0, 1'b0);
        @(negedge clk);
        set_upd(1'b1, 32'h100, BR, 1'b0, 32'h0, 6'd0, '0, 1'b0);
        @(negedge clk);
        // counter now 00; two taken updates, each lookup sees the pre-update value
        set_upd(1'b1, 32'h100, BR, 1'b1, 32'h80, 6'd0, '0, 1'b0); #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL nobypass_00 got=%b exp=0", bus.taken_o); end
        @(negedge clk); #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL nobypass_01 got=%b exp=0", bus.taken_o); end
        @(negedge clk); idle(); #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL retrain_10 got=%b exp=1", bus.taken_o); end
        @(negedge clk);
    endtask

    task automatic test_ghr();
        bus.pc_i = 32'h100; bus.fetch_adv_i = 1'b1; #1;
        vectors++; if (bus.ghr_o !== 6'b000000) begin miscompares++; $display("FAIL ghr_pre got=%b exp=000000", bus.ghr_o); end
        @(negedge clk); bus.fetch_adv_i = 1'b0; #1;
        vectors++; if (bus.ghr_o !== 6'b000001) begin miscompares++; $display("FAIL ghr_spec_shift got=%b exp=000001", bus.ghr_o); end
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL ghr_idx1_taken got=%b exp=0", bus.taken_o); end
        // speculative shift and mispredict restore in the same cycle
        bus.fetch_adv_i = 1'b1;
        set_upd(1'b1, 32'h300, BR, 1'b0, 32'h0, 6'b000101, '0, 1'b1);
        @(negedge clk); idle(); bus.fetch_adv_i = 1'b0; #1;
        vectors++; if (bus.ghr_o !== 6'b001010) begin miscompares++; $display("FAIL ghr_misp_branch got=%b exp=001010", bus.ghr_o); end
        set_upd(1'b1, 32'h400, JMP, 1'b1, 32'h500, 6'h2A, '0, 1'b1);
        @(negedge clk); idle();
        bus.pc_i = 32'h400; bus.fetch_adv_i = 1'b1; #1;
        vectors++; if (bus.ghr_o !== 6'h2A) begin miscompares++; $display("FAIL ghr_misp_jump got=%h exp=2a", bus.ghr_o); end
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL jump_taken got=%b exp=1", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h500) begin miscompares++; $display("FAIL jump_target got=%h exp=00000500", bus.target_o); end
        @(negedge clk); bus.fetch_adv_i = 1'b0; #1;
        vectors++; if (bus.ghr_o !== 6'h2A) begin miscompares++; $display("FAIL ghr_jump_noshift got=%h exp=2a", bus.ghr_o); end
    endtask

    task automatic test_alias();
        bus.pc_i = 32'h100; #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL alias_evicted_taken got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h104) begin miscompares++; $display("FAIL alias_evicted_target got=%h exp=00000104", bus.target_o); end
        set_upd(1'b1, 32'h100, BR, 1'b1, 32'h80, 6'h2A, '0, 1'b0);
        @(negedge clk); idle();
        bus.pc_i = 32'h400; #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL alias_second_evict got=%b exp=0", bus.taken_o); end
        bus.pc_i = 32'h100; #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL alias_rewrite_taken got=%b exp=1", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h80) begin miscompares++; $display("FAIL alias_rewrite_target got=%h exp=00000080", bus.target_o); end
        @(negedge clk);
    endtask

    task automatic test_return_btb();
`ifndef RAS_EN
        set_upd(1'b1, 32'h600, RET, 1'b1, 32'h700, 6'h2A, '0, 1'b0);
        @(negedge clk); idle();
        bus.pc_i = 32'h600; bus.fetch_adv_i = 1'b1; #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL ret_taken got=%b exp=1", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h700) begin miscompares++; $display("FAIL ret_btb_target got=%h exp=00000700", bus.target_o); end
        @(negedge clk); bus.fetch_adv_i = 1'b0; #1;
        vectors++; if (bus.ras_ptr_o !== 3'd0) begin miscompares++; $display("FAIL ret_ras_ptr got=%0d exp=0", bus.ras_ptr_o); end
`else
        set_upd(1'b1, 32'h600, RET, 1'b1, 32'h700, 6'h2A, '0, 1'b0);
        @(negedge clk); idle();
`endif
    endtask

    task automatic test_invalid_update();
        set_upd(1'b0, 32'h800, JMP, 1'b1, 32'h900, 6'h3F, 3'd5, 1'b1);
        bus.pc_i = 32'h100;
        @(negedge clk); idle(); #1;
        vectors++; if (bus.ghr_o !== 6'h2A) begin miscompares++; $display("FAIL inval_ghr got=%h exp=2a", bus.ghr_o); end
        bus.pc_i = 32'h800; #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL inval_btb_taken got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h804) begin miscompares++; $display("FAIL inval_btb_target got=%h exp=00000804", bus.target_o); end
        bus.pc_i = 32'h600; #1;
        vectors++; if (bus.taken_o !== 1'b1) begin miscompares++; $display("FAIL inval_kept_entry got=%b exp=1", bus.taken_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        bus.pc_i = 32'h600;
        #2 reset_ni = 1'b0;
        #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL midrst_taken got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.target_o !== 32'h604) begin miscompares++; $display("FAIL midrst_target got=%h exp=00000604", bus.target_o); end
        vectors++; if (bus.ghr_o !== 6'd0) begin miscompares++; $display("FAIL midrst_ghr got=%b exp=000000", bus.ghr_o); end
        #1 reset_ni = 1'b1;
        @(negedge clk); #1;
        vectors++; if (bus.taken_o !== 1'b0) begin miscompares++; $display("FAIL midrst_btb_cleared got=%b exp=0", bus.taken_o); end
        vectors++; if (bus.ghr_o !== 6'd0) begin miscompares++; $display("FAIL midrst_ghr_after got=%b exp=000000", bus.ghr_o); end
        @(negedge clk);
    endtask

    task automatic test_ras();
`ifdef RAS_EN
        set_upd(1'b1, 32'h200, CALL, 1'b1, 32'h1000, 6'd0, '0, 1'b0);
        @(negedge clk);
        set_upd(1'b1, 32'h1004, RET, 1'b1, 32'hDEAD0, 6'd0, '0, 1'b0);
        @(negedge clk);
        set_upd(1'b1, 32'h208, CALL, 1'b1, 32'h2000, 6'd0, '0, 1'b0);
        @(negedge clk); idle();
        bus.pc_i = 32'h200; bus.fetch_adv_i = 1'b1;
        @(negedge clk); bus.fetch_adv_i = 1'b0; bus.pc_i = 32'h1004; #1;
        vectors++; if (bus.ras_ptr_o !== 3'd1) begin miscompares++; $display("FAIL ras_push_ptr got=%0d exp=1", bus.ras_ptr_o); end
        vectors++; if (bus.target_o !== 32'h204) begin miscompares++; $display("FAIL ras_ret_target got=%h exp=00000204", bus.target_o); end
        bus.pc_i = 32'h208; bus.fetch_adv_i = 1'b1;
        repeat (RAS_DEPTH) @(negedge clk);
        bus.fetch_adv_i = 1'b0; bus.pc_i = 32'h1004; #1;
        vectors++; if (bus.ras_ptr_o !== 3'd1) begin miscompares++; $display("FAIL ras_wrap_ptr got=%0d exp=1", bus.ras_ptr_o); end
        vectors++; if (bus.target_o !== 32'h20C) begin miscompares++; $display("FAIL ras_overwrite got=%h exp=0000020c", bus.target_o); end
        bus.fetch_adv_i = 1'b1;
        @(negedge clk); bus.fetch_adv_i = 1'b0; #1;
        vectors++; if (bus.ras_ptr_o !== 3'd0) begin miscompares++; $display("FAIL ras_pop_ptr got=%0d exp=0", bus.ras_ptr_o); end
        set_upd(1'b1, 32'h300, BR, 1'b0, 32'h0, 6'd0, 3'd5, 1'b1);
        @(negedge clk); idle(); #1;
        vectors++; if (bus.ras_ptr_o !== 3'd5) begin miscompares++; $display("FAIL ras_restore got=%0d exp=5", bus.ras_ptr_o); end
        @(negedge clk);
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_train();
        test_saturation();
        test_ghr();
        test_alias();
        test_return_btb();
        test_invalid_update();
        test_reset_midrun();
        test_ras();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
